// File: rtl/obi_mux_2_to_1_if.sv
// rtl/obi_mux_2_to_1_if.sv - OBI address/response channel bundle shared by controllers and device
// master drives the address phase; slave returns grant and response.
interface obi_mux_2_to_1_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/obi_mux_2_to_1.sv
// rtl/obi_mux_2_to_1.sv - 2:1 round-robin OBI arbiter, one outstanding transaction
// OBI_MUX_TIMEOUT_EN adds a synthetic 0xDEADBEEF error response after TIMEOUT_CYCLES.
module obi_mux_2_to_1
`ifdef OBI_MUX_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 256)
`endif
(
  input  logic             clk_i,
  input  logic             rst_ni,
  obi_mux_2_to_1_if.slave  ctrl0,
  obi_mux_2_to_1_if.slave  ctrl1,
  obi_mux_2_to_1_if.master dev,
  output logic             timeout_o
);

  typedef enum logic {ST_IDLE, ST_WAIT_RESP} state_t;

  state_t r_state;
  logic   r_owner;
  logic   r_rr;
  logic   r_lock;
  logic   r_lock_sel;

  logic   w_sel;
  logic   w_can_issue;
  logic   w_grant;
  logic   w_resp;
  logic   w_tmo_fire;

`ifdef OBI_MUX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_tmo_cnt;

  assign w_tmo_fire = rst_ni & (r_state == ST_WAIT_RESP) & ~dev.rvalid & (r_tmo_cnt == CNT_LAST);
`else
  assign w_tmo_fire = 1'b0;
`endif

  // A stalled request keeps its selection until granted, regardless of priority.
  always_comb begin
    w_sel = 1'b0;
    if (r_lock) begin
      w_sel = r_lock_sel;
    end else if (ctrl0.req && ctrl1.req) begin
      w_sel = r_rr;
    end else if (ctrl1.req) begin
      w_sel = 1'b1;
    end
  end

  assign w_can_issue = rst_ni & ((r_state == ST_IDLE) | ((r_state == ST_WAIT_RESP) & dev.rvalid));
  assign w_resp      = rst_ni & (r_state == ST_WAIT_RESP) & (dev.rvalid | w_tmo_fire);

  assign dev.req   = w_can_issue & (w_sel ? ctrl1.req : ctrl0.req);
  assign dev.addr  = w_sel ? ctrl1.addr  : ctrl0.addr;
  assign dev.we    = w_sel ? ctrl1.we    : ctrl0.we;
  assign dev.be    = w_sel ? ctrl1.be    : ctrl0.be;
  assign dev.wdata = w_sel ? ctrl1.wdata : ctrl0.wdata;

  assign w_grant   = dev.req & dev.gnt;
  assign ctrl0.gnt = w_grant & ~w_sel;
  assign ctrl1.gnt = w_grant &  w_sel;

  assign ctrl0.rvalid = w_resp & ~r_owner;
  assign ctrl1.rvalid = w_resp &  r_owner;
  assign ctrl0.rdata  = w_tmo_fire ? 32'hDEAD_BEEF : dev.rdata;
  assign ctrl1.rdata  = w_tmo_fire ? 32'hDEAD_BEEF : dev.rdata;

  assign timeout_o = w_tmo_fire;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_rr       <= 1'b0;
      r_lock     <= 1'b0;
      r_lock_sel <= 1'b0;
`ifdef OBI_MUX_TIMEOUT_EN
      r_tmo_cnt  <= '0;
`endif
    end else if (w_grant) begin
      r_state <= ST_WAIT_RESP;
      r_owner <= w_sel;
      r_rr    <= ~w_sel;
      r_lock  <= 1'b0;
`ifdef OBI_MUX_TIMEOUT_EN
      r_tmo_cnt <= '0;
`endif
    end else begin
      if (dev.req) begin
        r_lock     <= 1'b1;
        r_lock_sel <= w_sel;
      end
      if (w_resp) begin
        r_state <= ST_IDLE;
      end
`ifdef OBI_MUX_TIMEOUT_EN
      else if ((r_state == ST_WAIT_RESP) && (r_tmo_cnt != CNT_LAST)) begin
        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      end
`endif
    end
  end

endmodule
